// File: rtl/debug_rgb_scan_driver_if.sv
// Signal bundle between the debug RGB source/board pins and the scan driver.
// The master side supplies the colour vectors and display controls; the slave
// side (the scan driver) returns the LED pin drive and the displayed image.
interface debug_rgb_scan_driver_if #(
  parameter int N_COLS   = 10,
  parameter int PWM_BITS = 4
);
  logic [N_COLS-1:0]   red_i;
  logic [N_COLS-1:0]   green_i;
  logic [N_COLS-1:0]   blue_i;
  logic [PWM_BITS-1:0] brightness_i;
  logic                freeze_i;
  logic [N_COLS-1:0]   col_sel_n_o;
  logic                red_n_o;
  logic                green_n_o;
  logic                blue_n_o;
  logic                frame_o;
  logic [3*N_COLS-1:0] display_o;

  modport master (
    output red_i, green_i, blue_i, brightness_i, freeze_i,
    input  col_sel_n_o, red_n_o, green_n_o, blue_n_o, frame_o, display_o
  );

  modport slave (
    input  red_i, green_i, blue_i, brightness_i, freeze_i,
    output col_sel_n_o, red_n_o, green_n_o, blue_n_o, frame_o, display_o
  );
endinterface

// File: rtl/debug_rgb_scan_driver.sv
// Debug RGB scan driver: brings the TCK-domain colour vectors into the system
// clock domain, rejects torn multi-bit updates, and scans N_COLS RGB LEDs that
// share active-low colour lines, with per-slot blanking and global PWM.
module debug_rgb_scan_driver #(
  parameter int N_COLS        = 10,
  parameter int SLOT_CYCLES   = 1024,
  parameter int BLANK_CYCLES  = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int PWM_BITS      = 4
) (
  input logic                   clock_i,
  input logic                   reset_n_i,
  debug_rgb_scan_driver_if.slave bus
);
  localparam int VW  = 3 * N_COLS;
  localparam int SW  = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
  localparam int CW  = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int STW = $clog2(STABLE_CYCLES + 1);

  localparam logic [SW-1:0]  SLOT_LAST    = SW'(SLOT_CYCLES - 1);
  localparam logic [SW-1:0]  BLANK_LIM    = SW'(BLANK_CYCLES);
  localparam logic [CW-1:0]  COL_LAST     = CW'(N_COLS - 1);
  localparam logic [STW-1:0] STAB_MAX     = STW'(STABLE_CYCLES);
  localparam logic [STW-1:0] STAB_ACCEPT  = STW'(STABLE_CYCLES - 1);
  localparam logic [N_COLS-1:0] COL_ONE   = N_COLS'(1);

  // ---------------- synchroniser and tearing filter ----------------
  logic [VW-1:0]  sync1_q, sync1_d;
  logic [VW-1:0]  sync_q, sync_d;
  logic [VW-1:0]  cand_q, cand_d;
  logic [VW-1:0]  pending_q, pending_d;
  logic [STW-1:0] stab_cnt_q, stab_cnt_d;

  // Two-flop sync, then accept a value only once it has held for STABLE_CYCLES.
  always_comb begin
    sync1_d   = {bus.red_i, bus.green_i, bus.blue_i};
    sync_d    = sync1_q;
    cand_d    = sync_q;
    pending_d = pending_q;
    if (sync_q != cand_q) begin
      stab_cnt_d = '0;
    end else begin
      stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + STW'(1);
      if (stab_cnt_q == STAB_ACCEPT) begin
        pending_d = cand_q;
      end
    end
  end

  // Filter state registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      cand_q     <= '0;
      pending_q  <= '0;
      stab_cnt_q <= '0;
    end else begin
      sync1_q    <= sync1_d;
      sync_q     <= sync_d;
      cand_q     <= cand_d;
      pending_q  <= pending_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // ---------------- scan counters and frame-latched image ----------------
  logic [SW-1:0]       slot_cnt_q, slot_cnt_d;
  logic [CW-1:0]       col_q, col_d;
  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [VW-1:0]       display_q, display_d;
  logic                frame_q, frame_d;
  logic                boundary;

  // Slot/column scan, free-running PWM, and image capture only at frame start
  // so a frame is never shown half old / half new.
  always_comb begin
    boundary   = (slot_cnt_q == '0) && (col_q == '0);
    slot_cnt_d = (slot_cnt_q == SLOT_LAST) ? '0 : slot_cnt_q + SW'(1);
    col_d      = col_q;
    if (slot_cnt_q == SLOT_LAST) begin
      col_d = (col_q == COL_LAST) ? '0 : col_q + CW'(1);
    end
    pwm_cnt_d  = pwm_cnt_q + PWM_BITS'(1);
    frame_d    = boundary;
    display_d  = display_q;
    if (boundary && !bus.freeze_i) begin
      display_d = pending_q;
    end
  end

  // Scan state registers.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      slot_cnt_q <= '0;
      col_q      <= '0;
      pwm_cnt_q  <= '0;
      display_q  <= '0;
      frame_q    <= 1'b0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      col_q      <= col_d;
      pwm_cnt_q  <= pwm_cnt_d;
      display_q  <= display_d;
      frame_q    <= frame_d;
    end
  end

  // ---------------- LED pin drive ----------------
  logic [N_COLS-1:0] disp_r, disp_g, disp_b;
  logic              pwm_on;
  logic [N_COLS-1:0] col_sel_n_q, col_sel_n_d;
  logic              red_n_q, red_n_d;
  logic              green_n_q, green_n_d;
  logic              blue_n_q, blue_n_d;

  // Blank the start of each slot to stop ghosting, otherwise select the
  // current LED and gate its colours with the brightness PWM.
  always_comb begin
    disp_r      = display_q[VW-1:2*N_COLS];
    disp_g      = display_q[2*N_COLS-1:N_COLS];
    disp_b      = display_q[N_COLS-1:0];
    pwm_on      = (&bus.brightness_i) || (pwm_cnt_q < bus.brightness_i);
    col_sel_n_d = '1;
    red_n_d     = 1'b1;
    green_n_d   = 1'b1;
    blue_n_d    = 1'b1;
    if (slot_cnt_q >= BLANK_LIM) begin
      col_sel_n_d = ~(COL_ONE << col_q);
      red_n_d     = ~(disp_r[col_q] & pwm_on);
      green_n_d   = ~(disp_g[col_q] & pwm_on);
      blue_n_d    = ~(disp_b[col_q] & pwm_on);
    end
  end

  // Pin registers; reset turns every LED off immediately.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      col_sel_n_q <= '1;
      red_n_q     <= 1'b1;
      green_n_q   <= 1'b1;
      blue_n_q    <= 1'b1;
    end else begin
      col_sel_n_q <= col_sel_n_d;
      red_n_q     <= red_n_d;
      green_n_q   <= green_n_d;
      blue_n_q    <= blue_n_d;
    end
  end

  assign bus.col_sel_n_o = col_sel_n_q;
  assign bus.red_n_o     = red_n_q;
  assign bus.green_n_o   = green_n_q;
  assign bus.blue_n_o    = blue_n_q;
  assign bus.frame_o     = frame_q;
  assign bus.display_o   = display_q;
endmodule

// File: tb/tb_debug_rgb_scan_driver.sv
// Directed bench for debug_rgb_scan_driver, run with short 64-cycle slots so
// each 10-LED frame is 640 cycles.
module tb_debug_rgb_scan_driver;
  localparam int N     = 10;
  localparam int SLOT  = 64;
  localparam int BLANK = 16;
  localparam int FRAME = N * SLOT;

  logic clk;
  logic rst_n;
  int   tests_run = 0;
  int   fails     = 0;

  // measurement results of one scanned frame
  int red_low_col [N];
  int red_low_total;
  int green_low;
  int blue_low;
  int blank_err;
  int sel_err;
  int active_sel;

  debug_rgb_scan_driver_if #(.N_COLS(N), .PWM_BITS(4)) bus_if ();

  debug_rgb_scan_driver #(
    .N_COLS(N), .SLOT_CYCLES(SLOT), .BLANK_CYCLES(BLANK),
    .STABLE_CYCLES(4), .PWM_BITS(4)
  ) dut (
    .clock_i  (clk),
    .reset_n_i(rst_n),
    .bus      (bus_if)
  );

  // ---------------- clock/reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- driver / measurement tasks ----------------
  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus_if.frame_o === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Called at the negedge showing frame_o; sample k shows col k/SLOT, slot k%SLOT.
  task automatic measure_frame();
    logic [N-1:0] exp_sel;
    int col;
    int slot;
    for (int c = 0; c < N; c++) red_low_col[c] = 0;
    red_low_total = 0; green_low = 0; blue_low = 0;
    blank_err = 0; sel_err = 0; active_sel = 0;
    for (int k = 0; k < FRAME; k++) begin
      col  = k / SLOT;
      slot = k % SLOT;
      if (bus_if.col_sel_n_o !== '1) active_sel++;
      if (slot < BLANK) begin
        if (bus_if.col_sel_n_o !== '1 || bus_if.red_n_o !== 1'b1 ||
            bus_if.green_n_o !== 1'b1 || bus_if.blue_n_o !== 1'b1) blank_err++;
      end else begin
        exp_sel = '1;
        exp_sel[col] = 1'b0;
        if (bus_if.col_sel_n_o !== exp_sel) sel_err++;
        if (bus_if.red_n_o === 1'b0) begin
          red_low_col[col]++;
          red_low_total++;
        end
        if (bus_if.green_n_o === 1'b0) green_low++;
        if (bus_if.blue_n_o === 1'b0) blue_low++;
      end
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus_if.red_i = '0; bus_if.green_i = '0; bus_if.blue_i = '0;
    bus_if.brightness_i = '0; bus_if.freeze_i = 1'b0;
    repeat (4) @(negedge clk);
    tests_run++;
    if (bus_if.col_sel_n_o !== 10'h3FF) begin
      fails++; $display("FAIL reset_sel: got %h expected 3ff", bus_if.col_sel_n_o);
    end
    tests_run++;
    if ({bus_if.red_n_o, bus_if.green_n_o, bus_if.blue_n_o} !== 3'b111) begin
      fails++; $display("FAIL reset_colours: got %b%b%b expected 111",
                        bus_if.red_n_o, bus_if.green_n_o, bus_if.blue_n_o);
    end
    tests_run++;
    if (bus_if.frame_o !== 1'b0) begin
      fails++; $display("FAIL reset_frame: got %b expected 0", bus_if.frame_o);
    end
    tests_run++;
    if (bus_if.display_o !== 30'h0) begin
      fails++; $display("FAIL reset_display: got %h expected 0", bus_if.display_o);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_single_red();
    bit ok;
    bus_if.red_i = 10'h001;
    bus_if.brightness_i = 4'hF;
    repeat (12) @(negedge clk);
    wait_frame(ok);
    tests_run++;
    if (ok !== 1'b1) begin
      fails++; $display("FAIL red_frame_wait: got timeout expected frame_o");
    end
    tests_run++;
    if (bus_if.display_o !== {10'h001, 20'h0}) begin
      fails++; $display("FAIL red_display: got %h expected %h", bus_if.display_o, {10'h001, 20'h0});
    end
    measure_frame();
    tests_run++;
    if (red_low_col[0] !== 48) begin
      fails++; $display("FAIL red_col0_on: got %0d expected 48", red_low_col[0]);
    end
    tests_run++;
    if (red_low_total !== 48) begin
      fails++; $display("FAIL red_other_cols_off: got %0d expected 48 total", red_low_total);
    end
    tests_run++;
    if (green_low + blue_low !== 0) begin
      fails++; $display("FAIL red_gb_off: got %0d expected 0", green_low + blue_low);
    end
    tests_run++;
    if (blank_err !== 0) begin
      fails++; $display("FAIL red_blanking: got %0d expected 0", blank_err);
    end
    tests_run++;
    if (sel_err !== 0) begin
      fails++; $display("FAIL red_select: got %0d expected 0", sel_err);
    end
  endtask

  task automatic test_glitch();
    int bad_toggle;
    int bad_settle;
    bit seen;
    bad_toggle = 0;
    bad_settle = 0;
    for (int j = 0; j < 700; j++) begin
      bus_if.red_i = ((j / 2) % 2 == 0) ? 10'h0F0 : 10'h155;
      @(negedge clk);
      if (bus_if.display_o[29:20] !== 10'h001) bad_toggle++;
    end
    tests_run++;
    if (bad_toggle !== 0) begin
      fails++; $display("FAIL glitch_hold: got %0d bad cycles expected 0", bad_toggle);
    end
    bus_if.red_i = 10'h2AA;
    repeat (12) begin
      @(negedge clk);
      if (bus_if.display_o[29:20] !== 10'h001 && bus_if.display_o[29:20] !== 10'h2AA) bad_settle++;
    end
    seen = 1'b0;
    for (int j = 0; j < 2 * FRAME; j++) begin
      @(negedge clk);
      if (bus_if.display_o[29:20] !== 10'h001 && bus_if.display_o[29:20] !== 10'h2AA) bad_settle++;
      if (bus_if.frame_o === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (seen !== 1'b1) begin
      fails++; $display("FAIL glitch_frame_wait: got timeout expected frame_o");
    end
    tests_run++;
    if (bus_if.display_o[29:20] !== 10'h2AA) begin
      fails++; $display("FAIL glitch_settle: got %h expected 2aa", bus_if.display_o[29:20]);
    end
    tests_run++;
    if (bad_settle !== 0) begin
      fails++; $display("FAIL glitch_intermediate: got %0d expected 0", bad_settle);
    end
  endtask

  task automatic test_pwm();
    bit ok;
    int bad_cols;
    bus_if.red_i = 10'h3FF;
    bus_if.brightness_i = 4'd4;
    repeat (12) @(negedge clk);
    wait_frame(ok);
    tests_run++;
    if (ok !== 1'b1) begin
      fails++; $display("FAIL pwm_frame_wait: got timeout expected frame_o");
    end
    measure_frame();
    bad_cols = 0;
    for (int c = 0; c < N; c++) if (red_low_col[c] !== 12) bad_cols++;
    tests_run++;
    if (bad_cols !== 0) begin
      fails++; $display("FAIL pwm_4of16_per_slot: got %0d slots off expected 0 (col0=%0d of 12)",
                        bad_cols, red_low_col[0]);
    end
    tests_run++;
    if (red_low_total !== 120) begin
      fails++; $display("FAIL pwm_total: got %0d expected 120", red_low_total);
    end
    bus_if.brightness_i = 4'd0;
    wait_frame(ok);
    measure_frame();
    tests_run++;
    if (red_low_total !== 0) begin
      fails++; $display("FAIL pwm_zero_off: got %0d expected 0", red_low_total);
    end
    tests_run++;
    if (active_sel !== 480) begin
      fails++; $display("FAIL pwm_zero_scan: got %0d expected 480", active_sel);
    end
  endtask

  task automatic test_freeze();
    bit ok;
    bus_if.brightness_i = 4'hF;
    bus_if.freeze_i = 1'b1;
    bus_if.green_i = 10'h155;
    for (int f = 0; f < 3; f++) begin
      wait_frame(ok);
      tests_run++;
      if (ok !== 1'b1 || bus_if.display_o !== {10'h3FF, 20'h0}) begin
        fails++; $display("FAIL freeze_hold_%0d: got %h expected %h", f, bus_if.display_o, {10'h3FF, 20'h0});
      end
    end
    bus_if.freeze_i = 1'b0;
    wait_frame(ok);
    tests_run++;
    if (ok !== 1'b1 || bus_if.display_o !== {10'h3FF, 10'h155, 10'h0}) begin
      fails++; $display("FAIL freeze_release: got %h expected %h", bus_if.display_o, {10'h3FF, 10'h155, 10'h0});
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    bus_if.green_i = 10'h0;
    wait_frame(ok);
    repeat (5 * SLOT + 30) @(negedge clk);
    tests_run++;
    if (bus_if.col_sel_n_o !== 10'h3DF || bus_if.red_n_o !== 1'b0) begin
      fails++; $display("FAIL areset_pre: got sel=%h red_n=%b expected sel=3df red_n=0",
                        bus_if.col_sel_n_o, bus_if.red_n_o);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_if.col_sel_n_o !== 10'h3FF ||
        {bus_if.red_n_o, bus_if.green_n_o, bus_if.blue_n_o} !== 3'b111) begin
      fails++; $display("FAIL areset_off: got sel=%h rgb_n=%b%b%b expected sel=3ff rgb_n=111",
                        bus_if.col_sel_n_o, bus_if.red_n_o, bus_if.green_n_o, bus_if.blue_n_o);
    end
    tests_run++;
    if (bus_if.display_o !== 30'h0 || bus_if.frame_o !== 1'b0) begin
      fails++; $display("FAIL areset_state: got display=%h frame=%b expected 0/0",
                        bus_if.display_o, bus_if.frame_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests_run++;
    if (bus_if.frame_o !== 1'b1 || bus_if.col_sel_n_o !== 10'h3FF) begin
      fails++; $display("FAIL areset_first_frame: got frame=%b sel=%h expected 1/3ff",
                        bus_if.frame_o, bus_if.col_sel_n_o);
    end
    @(negedge clk);
    tests_run++;
    if (bus_if.frame_o !== 1'b0) begin
      fails++; $display("FAIL areset_frame_pulse: got %b expected 0", bus_if.frame_o);
    end
    repeat (15) @(negedge clk);
    tests_run++;
    if (bus_if.col_sel_n_o !== 10'h3FE || bus_if.red_n_o !== 1'b1) begin
      fails++; $display("FAIL areset_restart_col0: got sel=%h red_n=%b expected 3fe/1",
                        bus_if.col_sel_n_o, bus_if.red_n_o);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_red();
    test_glitch();
    test_pwm();
    test_freeze();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
